fdivsqrtseq: RTL and testbench

Parametrised successor sequencer for the iterative divide/square-root datapath. It adds a one-entry request buffer with a valid/ready handshake, so a new operation can be accepted while one is running and launched back-to-back from DONE. It also adds a tagged completion, a visible step counter and a zero-cycle boundary rule. It sits between the FPU decode/issue logic and the divsqrt iteration/post-processing stages.

---
 rtl/fdivsqrtseq.sv | 155 +++++++++++++++
 tb/tb_fdivsqrtseq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdivsqrtseq.sv
// Sequencer for the iterative divide/square-root datapath.
// Holds one active operation plus a one-entry request buffer, so a queued
// operation can launch in the same cycle the previous one reports Done.
// Completion carries the operation tag and a flag for special-case results.

module fdivsqrtseq #(
  parameter int unsigned DURLEN      = 6,
  parameter int unsigned TAGW        = 3,
  parameter int unsigned IDIV_ON_FPU = 1
) (
  input  logic              clk,
  input  logic              reset,

  // Request side
  input  logic              ReqValid,
  input  logic              ReqInt,
  input  logic              ReqSqrt,
  input  logic [TAGW-1:0]   ReqTag,
  input  logic [DURLEN-1:0] ReqCycles,
  input  logic              XZero,
  input  logic              XInf,
  input  logic              XNaN,
  input  logic              Xs,
  input  logic              YZero,
  input  logic              YInf,
  input  logic              YNaN,
  input  logic              ISpecialCase,
  output logic              ReqReady,

  // Pipeline control
  input  logic              Stall,
  input  logic              Flush,
  input  logic              WZero,

  // Status
  output logic              Start,
  output logic              Busy,
  output logic              Done,
  output logic              SpecialCase,
  output logic [TAGW-1:0]   DoneTag,
  output logic [DURLEN-1:0] StepCnt
);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } stateT;

  stateT             state;

  // One-entry request buffer
  logic              pendValid;
  logic [TAGW-1:0]   pendTag;
  logic [DURLEN-1:0] pendCycles;
  logic              pendSpecial;

  logic              reqIsInt;
  logic              fSpecial;
  logic              reqSpecial;
  logic              launchOk;
  logic              launchPend;
  logic              launchReq;
  logic              accept;
  logic              bufWrite;
  logic [TAGW-1:0]   launchTag;
  logic [DURLEN-1:0] launchCycles;
  logic              launchSpecial;
  logic              launchToDone;

  // Classify the incoming request and decide what, if anything, launches now
  always_comb begin
    reqIsInt   = ReqInt & (IDIV_ON_FPU != 0);
    fSpecial   = XZero | XInf | XNaN | (Xs & ReqSqrt) | ((YZero | YInf | YNaN) & ~ReqSqrt);
    reqSpecial = reqIsInt ? ISpecialCase : fSpecial;

    ReqReady   = ~pendValid & ~Flush;
    launchOk   = ~Stall & ~Flush & ((state == StIdle) | (state == StDone));
    Start      = launchOk & (pendValid | ReqValid);
    Busy       = (state == StBusy) | Start;

    // The buffered op always goes first; the live request launches only if nothing waits
    launchPend = Start & pendValid;
    launchReq  = Start & ~pendValid;
    accept     = ReqValid & ReqReady;
    bufWrite   = accept & ~launchReq;

    launchTag     = pendValid ? pendTag     : ReqTag;
    launchCycles  = pendValid ? pendCycles  : ReqCycles;
    launchSpecial = pendValid ? pendSpecial : reqSpecial;
    // Special results and zero-length ops skip iteration entirely
    launchToDone  = launchSpecial | (launchCycles == '0);
  end

  // FSM, request buffer and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= StIdle;
      Done        <= 1'b0;
      pendValid   <= 1'b0;
      pendTag     <= '0;
      pendCycles  <= '0;
      pendSpecial <= 1'b0;
      StepCnt     <= '0;
      DoneTag     <= '0;
      SpecialCase <= 1'b0;
    end else if (Flush) begin
      // Flush drops all work but leaves the last op's status visible
      state     <= StIdle;
      Done      <= 1'b0;
      pendValid <= 1'b0;
    end else begin
      if (bufWrite) begin
        pendValid   <= 1'b1;
        pendTag     <= ReqTag;
        pendCycles  <= ReqCycles;
        pendSpecial <= reqSpecial;
      end else if (launchPend) begin
        pendValid <= 1'b0;
      end

      if (Start) begin
        StepCnt     <= launchCycles;
        DoneTag     <= launchTag;
        SpecialCase <= launchSpecial;
        state       <= launchToDone ? StDone : StBusy;
        Done        <= launchToDone;
      end else begin
        case (state)
          StBusy: begin
            // Iteration keeps running under Stall; only launch and DONE exit wait
            if (StepCnt != '0) begin
              StepCnt <= StepCnt - DURLEN'(1);
            end
            if ((StepCnt <= DURLEN'(1)) || WZero) begin
              state <= StDone;
              Done  <= 1'b1;
            end
          end
          StDone: begin
            if (!Stall) begin
              state <= StIdle;
              Done  <= 1'b0;
            end
          end
          default: begin
            state <= StIdle;
            Done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fdivsqrtseq.sv
// Directed bench for fdivsqrtseq: timeline checks plus a tag/special scoreboard.

module tb_fdivsqrtseq;

  localparam int unsigned DURLEN = 6;
  localparam int unsigned TAGW   = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ReqValid, ReqInt, ReqSqrt;
  logic [TAGW-1:0]   ReqTag;
  logic [DURLEN-1:0] ReqCycles;
  logic              XZero, XInf, XNaN, Xs, YZero, YInf, YNaN, ISpecialCase;
  logic              ReqReady;
  logic              Stall, Flush, WZero;
  logic              Start, Busy, Done, SpecialCase;
  logic [TAGW-1:0]   DoneTag;
  logic [DURLEN-1:0] StepCnt;

  fdivsqrtseq #(
    .DURLEN      (DURLEN),
    .TAGW        (TAGW),
    .IDIV_ON_FPU (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ReqValid     (ReqValid),
    .ReqInt       (ReqInt),
    .ReqSqrt      (ReqSqrt),
    .ReqTag       (ReqTag),
    .ReqCycles    (ReqCycles),
    .XZero        (XZero),
    .XInf         (XInf),
    .XNaN         (XNaN),
    .Xs           (Xs),
    .YZero        (YZero),
    .YInf         (YInf),
    .YNaN         (YNaN),
    .ISpecialCase (ISpecialCase),
    .ReqReady     (ReqReady),
    .Stall        (Stall),
    .Flush        (Flush),
    .WZero        (WZero),
    .Start        (Start),
    .Busy         (Busy),
    .Done         (Done),
    .SpecialCase  (SpecialCase),
    .DoneTag      (DoneTag),
    .StepCnt      (StepCnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [TAGW:0] sb[$];  // {special, tag} of each accepted op, in completion order
  bit sampled = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic sp, input logic [TAGW-1:0] tag);
    sb.push_back({sp, tag});
  endtask

  // Sample point of the current cycle; retire an op when Done leaves
  task automatic half();
    logic [TAGW:0] e;
    @(negedge clk);
    sampled = 1'b1;
    if (reset && Done && !Stall && !Flush) begin
      chk("sb_avail", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("done_tag", 32'(DoneTag), 32'(e[TAGW-1:0]));
        chk("done_special", 32'(SpecialCase), 32'(e[TAGW]));
      end
    end
  endtask

  task automatic nxt();
    if (!sampled) half();
    @(posedge clk);
    #1;
    sampled = 1'b0;
  endtask

  task automatic clearIn();
    ReqValid = 0; ReqInt = 0; ReqSqrt = 0; ReqTag = '0; ReqCycles = '0;
    XZero = 0; XInf = 0; XNaN = 0; Xs = 0; YZero = 0; YInf = 0; YNaN = 0;
    ISpecialCase = 0;
  endtask

  task automatic drive(input logic [TAGW-1:0] tag, input logic [DURLEN-1:0] cyc);
    clearIn();
    ReqValid  = 1;
    ReqTag    = tag;
    ReqCycles = cyc;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      nxt();
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clearIn();
    Stall = 0; Flush = 0; WZero = 0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_start", Start, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_step", StepCnt, 0);
    chk("rst_tag", DoneTag, 0);
    chk("rst_special", SpecialCase, 0);
    #2 reset = 1'b1;
    sampled = 1'b1;
    nxt();
    chk("rst_ready", ReqReady, 1);

    // Normal op, 4 cycles
    drive(3'd5, 6'd4); push(1'b0, 3'd5);
    half();
    chk("n_start", Start, 1); chk("n_busy0", Busy, 1); chk("n_ready", ReqReady, 1);
    nxt(); clearIn();
    for (int c = 1; c <= 4; c++) begin
      half();
      chk("n_busy", Busy, 1); chk("n_nodone", Done, 0); chk("n_nostart", Start, 0);
      chk("n_step", StepCnt, 32'(5 - c));
      nxt();
    end
    half(); chk("n_done", Done, 1); chk("n_busy5", Busy, 0);
    nxt();
    half(); chk("n_done_gone", Done, 0);
    nxt();

    // Special divide (XZero)
    drive(3'd3, 6'd10); XZero = 1; push(1'b1, 3'd3);
    half(); chk("s_start", Start, 1); chk("s_busy0", Busy, 1);
    nxt(); clearIn();
    half(); chk("s_done", Done, 1); chk("s_busy1", Busy, 0); chk("s_flag", SpecialCase, 1);
    nxt();
    half(); chk("s_done_gone", Done, 0);
    nxt();

    // Back-to-back via the buffer, third request refused
    drive(3'd1, 6'd3); push(1'b0, 3'd1);
    half(); chk("b_startA", Start, 1);
    nxt();
    drive(3'd2, 6'd2); push(1'b0, 3'd2);
    half(); chk("b_readyB", ReqReady, 1); chk("b_nostartB", Start, 0);
    nxt();
    drive(3'd7, 6'd5);
    half(); chk("b_full2", ReqReady, 0);
    nxt();
    half(); chk("b_full3", ReqReady, 0); chk("b_nodone3", Done, 0);
    nxt();
    half(); chk("b_done4", Done, 1); chk("b_start4", Start, 1); chk("b_full4", ReqReady, 0);
    nxt(); clearIn();
    half(); chk("b_tag5", DoneTag, 2); chk("b_done5", Done, 0); chk("b_busy5", Busy, 1);
    chk("b_step5", StepCnt, 2);
    nxt();
    half(); chk("b_busy6", Busy, 1);
    nxt();
    half(); chk("b_done7", Done, 1);
    nxt();
    half(); chk("b_idle8", Done, 0); chk("b_ready8", ReqReady, 1);
    nxt();

    // Early termination on WZero
    drive(3'd4, 6'd20); push(1'b0, 3'd4);
    half();
    nxt(); clearIn();
    half(); chk("w_step1", StepCnt, 20);
    nxt();
    WZero = 1;
    half(); chk("w_step2", StepCnt, 19); chk("w_nodone2", Done, 0);
    nxt(); WZero = 0;
    half(); chk("w_done3", Done, 1); chk("w_step3", StepCnt, 18);
    nxt();

    // Stall holds DONE and blocks the pending launch
    drive(3'd6, 6'd1); push(1'b0, 3'd6);
    half();
    nxt();
    drive(3'd3, 6'd1); push(1'b0, 3'd3);
    half();
    nxt(); clearIn();
    Stall = 1;
    for (int k = 0; k < 3; k++) begin
      half(); chk("st_hold", Done, 1); chk("st_nostart", Start, 0);
      nxt();
    end
    Stall = 0;
    half(); chk("st_done", Done, 1); chk("st_start", Start, 1); chk("st_tag", DoneTag, 6);
    nxt();
    half(); chk("st_busyE", Busy, 1); chk("st_tagE", DoneTag, 3);
    nxt();
    half(); chk("st_doneE", Done, 1);
    nxt();

    // Flush in BUSY with a pending op
    drive(3'd1, 6'd8); push(1'b0, 3'd1);
    half();
    nxt();
    drive(3'd2, 6'd3); push(1'b0, 3'd2);
    half();
    nxt(); clearIn();
    Flush = 1;
    half(); chk("f_nostart", Start, 0); chk("f_noready", ReqReady, 0); chk("f_busy", Busy, 1);
    nxt(); Flush = 0;
    sb.delete();
    half();
    chk("f_idle", Busy, 0); chk("f_nodone", Done, 0); chk("f_ready", ReqReady, 1);
    chk("f_nopend", Start, 0); chk("f_step", StepCnt, 7); chk("f_tag", DoneTag, 1);
    nxt();
    for (int k = 0; k < 5; k++) begin
      half(); chk("f_quiet_done", Done, 0); chk("f_quiet_busy", Busy, 0);
      nxt();
    end

    // Asynchronous reset mid-BUSY
    drive(3'd5, 6'd6); push(1'b0, 3'd5);
    half();
    nxt(); clearIn();
    half();
    nxt();
    #1 reset = 1'b0;
    #1;
    chk("ar_busy", Busy, 0); chk("ar_done", Done, 0); chk("ar_step", StepCnt, 0);
    chk("ar_tag", DoneTag, 0); chk("ar_special", SpecialCase, 0); chk("ar_start", Start, 0);
    sb.delete();
    @(negedge clk);
    #2 reset = 1'b1;
    sampled = 1'b1;
    nxt();
    for (int k = 0; k < 3; k++) begin
      half(); chk("ar_nodone", Done, 0); chk("ar_ready", ReqReady, 1);
      nxt();
    end

    // Classification corner cases through the scoreboard
    drive(3'd2, 6'd5); ReqInt = 1; ISpecialCase = 1; push(1'b1, 3'd2);
    nxt(); clearIn(); drain(12);
    drive(3'd3, 6'd2); ReqInt = 1; XNaN = 1; push(1'b0, 3'd3);
    nxt(); clearIn(); drain(12);
    drive(3'd4, 6'd3); ReqSqrt = 1; Xs = 1; push(1'b1, 3'd4);
    nxt(); clearIn(); drain(12);
    drive(3'd5, 6'd2); ReqSqrt = 1; YZero = 1; push(1'b0, 3'd5);
    nxt(); clearIn(); drain(12);
    drive(3'd6, 6'd2); YInf = 1; push(1'b1, 3'd6);
    nxt(); clearIn(); drain(12);

    // Zero-cycle op finishes like a special one
    drive(3'd7, 6'd0); push(1'b0, 3'd7);
    half(); chk("z_start", Start, 1);
    nxt(); clearIn();
    half(); chk("z_done", Done, 1); chk("z_busy", Busy, 0);
    nxt();

    drain(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
